// File: rtl/seq_detect_param.sv
// Serial pattern detector: a LEN-bit shift window is compared against a reloadable
// pattern register, and matches are tallied in a saturating counter.
module seq_detect_param #(
  parameter int               LEN     = 5,
  parameter logic [LEN-1:0]   PATTERN = 5'b10010,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             j,
  input  logic             ovl,
  input  logic             pat_ld,
  input  logic [LEN-1:0]   pat_in,
  input  logic             clr,
  output logic             w,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int               FILL_W  = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [LEN-1:0]    pat_q, pat_d;
  logic [LEN-1:0]    sh_q, sh_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              w_q, w_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;

  logic [LEN-1:0]    nsh;
  logic [FILL_W-1:0] nfill;
  logic              hit;

  assign nsh   = {sh_q[LEN-2:0], j};
  assign nfill = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
  // A pattern load discards the sample on the same edge, so it can never hit.
  assign hit   = en && !pat_ld && (nfill == FILL_MAX) && (nsh == pat_q);

  always_comb begin
    pat_d  = pat_q;
    sh_d   = sh_q;
    fill_d = fill_q;
    w_d    = 1'b0;
    if (pat_ld) begin
      pat_d  = pat_in;
      sh_d   = '0;
      fill_d = '0;
    end else if (en) begin
      sh_d   = nsh;
      w_d    = hit;
      // Non-overlapping mode restarts the fill so the next match needs LEN fresh bits.
      fill_d = (hit && !ovl) ? '0 : nfill;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_MAX - 1'b1) sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= PATTERN;
      sh_q   <= '0;
      fill_q <= '0;
      w_q    <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      sh_q   <= sh_d;
      fill_q <= fill_d;
      w_q    <= w_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign w         = w_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: an 8-bit-counter instance plus a 2-bit-counter
// instance driven by the same stimulus, so saturation can be exercised cheaply.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, j = 1'b0, ovl = 1'b0, pat_ld = 1'b0, clr = 1'b0;
  logic [4:0] pat_in = '0;
  logic       w, w2, sat, sat2;
  logic [7:0] cnt;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.LEN(5), .PATTERN(5'b10010), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .j(j), .ovl(ovl), .pat_ld(pat_ld),
    .pat_in(pat_in), .clr(clr), .w(w), .match_cnt(cnt), .cnt_sat(sat));

  seq_detect_param #(.LEN(5), .PATTERN(5'b10010), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .j(j), .ovl(ovl), .pat_ld(pat_ld),
    .pat_in(pat_in), .clr(clr), .w(w2), .match_cnt(cnt2), .cnt_sat(sat2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one bit on the next edge and check the registered pulse right after it.
  task automatic send(input logic b, input logic exp_w, input string tag);
    en = 1'b1; j = b;
    @(posedge clk); #1;
    chk(tag, w, exp_w);
  endtask

  // Bits are sent MSB first; wexp holds the expected w after each bit.
  task automatic send_seq(input logic [15:0] bits, input logic [15:0] wexp, input int n,
                          input string tag);
    for (int i = n - 1; i >= 0; i--) send(bits[i], wexp[i], tag);
  endtask

  task automatic idle(input string tag);
    en = 1'b0;
    @(posedge clk); #1;
    chk(tag, w, 1'b0);
  endtask

  // Reset is pulsed between edges to exercise the asynchronous path.
  task automatic pulse_reset();
    en = 1'b0; clr = 1'b0; pat_ld = 1'b0;
    #1 rst = 1'b0;
    #1 rst = 1'b1;
  endtask

  initial begin
    #12;
    chk("rst_w", w, 1'b0);
    chk("rst_cnt", cnt, 8'd0);
    chk("rst_sat", sat, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Basic non-overlapping match
    ovl = 1'b0;
    send_seq(16'b10010, 16'b00001, 5, "t1_w");
    chk("t1_cnt", cnt, 8'd1);
    idle("t1_w_drop");

    // Overlapping: second match reuses the trailing "10"
    pulse_reset();
    ovl = 1'b1;
    send_seq(16'b10010010, 16'b00001001, 8, "t2_ovl_w");
    chk("t2_ovl_cnt", cnt, 8'd2);
    pulse_reset();
    ovl = 1'b0;
    send_seq(16'b10010010, 16'b00001000, 8, "t2_novl_w");
    chk("t2_novl_cnt", cnt, 8'd1);

    // Enable gaps between accepted bits
    pulse_reset();
    send(1'b1, 1'b0, "t3_w"); idle("t3_gap"); idle("t3_gap");
    send(1'b0, 1'b0, "t3_w"); idle("t3_gap"); idle("t3_gap");
    send(1'b0, 1'b0, "t3_w"); idle("t3_gap"); idle("t3_gap");
    send(1'b1, 1'b0, "t3_w"); idle("t3_gap"); idle("t3_gap");
    send(1'b0, 1'b1, "t3_w5"); idle("t3_gap"); idle("t3_gap");
    chk("t3_cnt", cnt, 8'd1);

    // Runtime pattern load discards the partial window and the same-edge sample
    pulse_reset();
    send_seq(16'b100, 16'b000, 3, "t4_pre");
    pat_ld = 1'b1; pat_in = 5'b11011;
    send(1'b1, 1'b0, "t4_ld");
    pat_ld = 1'b0;
    send_seq(16'b10, 16'b00, 2, "t4_post");
    send_seq(16'b11011, 16'b00001, 5, "t4_new_pat");
    chk("t4_cnt", cnt, 8'd1);
    send_seq(16'b10010, 16'b00000, 5, "t4_old_pat");
    chk("t4_cnt_hold", cnt, 8'd1);

    // Saturation on the 2-bit counter, then clear colliding with a match
    pulse_reset();
    send_seq(16'b10010, 16'b00001, 5, "t5_w");
    chk("t5_c2_1", cnt2, 2'd1); chk("t5_s2_1", sat2, 1'b0);
    send_seq(16'b10010, 16'b00001, 5, "t5_w");
    chk("t5_c2_2", cnt2, 2'd2); chk("t5_s2_2", sat2, 1'b0);
    send_seq(16'b10010, 16'b00001, 5, "t5_w");
    chk("t5_c2_3", cnt2, 2'd3); chk("t5_s2_3", sat2, 1'b1);
    send_seq(16'b10010, 16'b00001, 5, "t5_w");
    chk("t5_c2_4", cnt2, 2'd3); chk("t5_s2_4", sat2, 1'b1);
    chk("t5_c8_4", cnt, 8'd4); chk("t5_s8_4", sat, 1'b0);
    send_seq(16'b1001, 16'b0000, 4, "t5_w");
    clr = 1'b1;
    send(1'b0, 1'b1, "t5_clr_w");
    clr = 1'b0;
    chk("t5_clr_w2", w2, 1'b1);
    chk("t5_clr_c2", cnt2, 2'd0); chk("t5_clr_s2", sat2, 1'b0);
    chk("t5_clr_c8", cnt, 8'd0);

    // Asynchronous reset: takes effect before the next edge
    pulse_reset();
    send_seq(16'b10010, 16'b00001, 5, "t6_w");
    #1 rst = 1'b0;
    #1;
    chk("t6_async_w", w, 1'b0);
    chk("t6_async_cnt", cnt, 8'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    send_seq(16'b1001, 16'b0000, 4, "t6_pre");
    #1 rst = 1'b0;
    #1 rst = 1'b1;
    send(1'b0, 1'b0, "t6_no_span");
    chk("t6_cnt0", cnt, 8'd0);
    send_seq(16'b10010, 16'b00001, 5, "t6_full");
    chk("t6_cnt1", cnt, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
